// File: rtl/hwpe_stream_upsizer_if.sv
// HWPE-Stream handshake bundle: valid/ready with byte strobes.
// master drives the beat, slave returns ready.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                      valid;
  logic                      ready;
  logic [DATA_WIDTH-1:0]     data;
  logic [DATA_WIDTH/8-1:0]   strb;

  modport master (output valid, output data, output strb, input  ready);
  modport slave  (input  valid, input  data, input  strb, output ready);
endinterface

// File: rtl/hwpe_stream_upsizer.sv
// Packs RATIO narrow HWPE-Stream beats into one wide beat, lane 0 first.
// flush_i emits a partial word with zeroed unfilled lanes; clear_i drops everything.
module hwpe_stream_upsizer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RATIO      = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         flush_i,
  output logic [$clog2(RATIO+1)-1:0]   count_o,
  hwpe_stream_intf_stream.slave        push_i,
  hwpe_stream_intf_stream.master       pop_o
);

  localparam int unsigned STRB_W  = DATA_WIDTH / 8;
  localparam int unsigned CNT_W   = $clog2(RATIO + 1);
  localparam int unsigned WDATA_W = RATIO * DATA_WIDTH;
  localparam int unsigned WSTRB_W = RATIO * STRB_W;

  if (RATIO < 2) begin : g_bad_ratio
    $error("hwpe_stream_upsizer: RATIO must be at least 2");
  end
  if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("hwpe_stream_upsizer: DATA_WIDTH must be a multiple of 8");
  end

  typedef enum logic [1:0] {
    FILL = 2'd0,
    FULL = 2'd1,
    PART = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [WDATA_W-1:0]   data_q, data_d;
  logic [WSTRB_W-1:0]   strb_q, strb_d;
  logic                 valid_q, valid_d;
  logic                 push_ready;
  logic                 push_hs;
  logic                 pop_hs;

  // valid_q mirrors (state != FILL), so ready never sees clear_i or data
  assign push_ready   = ~valid_q | pop_o.ready;
  assign push_hs      = push_i.valid & push_ready;
  assign pop_hs       = valid_q & pop_o.ready;
  assign push_i.ready = push_ready;

  assign pop_o.valid = valid_q;
  assign pop_o.data  = data_q;
  assign pop_o.strb  = strb_q;
  assign count_o     = cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    strb_d  = strb_q;
    cnt_inc = cnt_q + CNT_W'(1);

    if (clear_i) begin
      state_d = FILL;
      cnt_d   = '0;
      data_d  = '0;
      strb_d  = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (push_hs) begin
            for (int unsigned k = 0; k < RATIO; k++) begin
              if (k == 32'(cnt_q)) begin
                data_d[k*DATA_WIDTH +: DATA_WIDTH] = push_i.data;
                strb_d[k*STRB_W     +: STRB_W]     = push_i.strb;
              end
            end
            cnt_d = cnt_inc;
          end
          // a push that completes the word wins over a same-cycle flush
          if (push_hs && (cnt_inc == CNT_W'(RATIO))) begin
            state_d = FULL;
          end else if (flush_i && (push_hs || (cnt_q != '0))) begin
            state_d = PART;
          end
        end
        FULL, PART: begin
          if (pop_hs) begin
            state_d = FILL;
            data_d  = '0;
            strb_d  = '0;
            cnt_d   = '0;
            if (push_hs) begin
              data_d[DATA_WIDTH-1:0] = push_i.data;
              strb_d[STRB_W-1:0]     = push_i.strb;
              cnt_d                  = CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = FILL;
          cnt_d   = '0;
          data_d  = '0;
          strb_d  = '0;
        end
      endcase
    end

    valid_d = (state_d != FILL);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FILL;
      cnt_q   <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      valid_q <= valid_d;
    end
  end

`ifndef SYNTHESIS
  // clear_i legitimately retracts a stalled output word
  a_pop_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (pop_o.valid && !pop_o.ready && !clear_i) |=> (pop_o.valid && $stable(pop_o.data)));
  a_push_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (push_i.valid && !push_i.ready) |=> (push_i.valid && $stable(push_i.data)));
`endif

endmodule

// File: tb/tb_hwpe_stream_upsizer.sv
// Self-checking bench for hwpe_stream_upsizer (DATA_WIDTH=32, RATIO=4):
// directed vector table, hand-written multi-cycle sequences and a random soak.
module tb_hwpe_stream_upsizer;

  localparam int unsigned DW = 32;
  localparam int unsigned R  = 4;

  logic       clk;
  logic       rst_ni;
  logic       clear_i;
  logic       flush_i;
  logic [2:0] count_o;

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW))   push_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(R*DW)) pop_if ();

  hwpe_stream_upsizer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .flush_i (flush_i),
    .count_o (count_o),
    .push_i  (push_if.slave),
    .pop_o   (pop_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         pv;
    logic [31:0]  pd;
    logic [3:0]   ps;
    logic         fl;
    logic         cl;
    logic [2:0]   ecnt;
    logic         ev;
    logic [127:0] ed;
    logic [15:0]  es;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] w4(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  function automatic vec_t v(input logic pv, input logic [31:0] pd, input logic fl,
                             input logic cl, input logic [2:0] ecnt, input logic ev,
                             input logic [127:0] ed, input logic [15:0] es);
    vec_t r;
    r.pv = pv; r.pd = pd; r.ps = 4'hF; r.fl = fl; r.cl = cl;
    r.ecnt = ecnt; r.ev = ev; r.ed = ed; r.es = es;
    return r;
  endfunction

  task automatic drive(input logic pv, input logic [31:0] pd, input logic [3:0] ps,
                       input logic fl, input logic cl, input logic pr);
    push_if.valid = pv;
    push_if.data  = pd;
    push_if.strb  = ps;
    flush_i       = fl;
    clear_i       = cl;
    pop_if.ready  = pr;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, 128'(count_o), 128'd0);
    chk({tag, "_valid"}, 128'(pop_if.valid), 128'd0);
    chk({tag, "_data"},  pop_if.data, 128'd0);
    chk({tag, "_strb"},  128'(pop_if.strb), 128'd0);
    chk({tag, "_pready"}, 128'(push_if.ready), 128'd1);
  endtask

  // 0x11..0x44 back-to-back; wide beat must appear exactly one cycle after the 4th push
  task automatic run_basic(input string tag);
    logic [31:0] b;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b = 32'h11 * (i + 1);
      drive(1'b1, b, 4'hF, 1'b0, 1'b0, 1'b1);
      #1 chk({tag, "_novalid"}, 128'(pop_if.valid), 128'd0);
    end
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    #1;
    chk({tag, "_valid"}, 128'(pop_if.valid), 128'd1);
    chk({tag, "_data"},  pop_if.data, w4(32'h11, 32'h22, 32'h33, 32'h44));
    chk({tag, "_strb"},  128'(pop_if.strb), 128'hFFFF);
    chk({tag, "_count"}, 128'(count_o), 128'd4);
    @(negedge clk);
    #1 chk({tag, "_after"}, 128'(pop_if.valid), 128'd0);
  endtask

  // soak state
  logic [31:0]  pend_d[$];
  logic [3:0]   pend_s[$];
  logic [127:0] exp_d[$];
  logic [15:0]  exp_s[$];

  initial begin
    vec_t         t;
    logic [127:0] wd;
    logic [15:0]  ws;
    logic         pv;
    logic [31:0]  pdat;
    logic [3:0]   pstr;
    logic         push_hs;
    logic         pop_hs;
    logic         hs_prev;
    int           sent;
    int           rcvd;
    int           cyc;

    rst_ni = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1 chk_reset_vals("reset");
    @(negedge clk);
    rst_ni = 1'b1;

    // basic packing
    vecs.push_back(v(1, 32'h11, 0, 0, 0, 0, '0, 16'h0000));
    vecs.push_back(v(1, 32'h22, 0, 0, 1, 0, w4(32'h11, 0, 0, 0), 16'h000F));
    vecs.push_back(v(1, 32'h33, 0, 0, 2, 0, w4(32'h11, 32'h22, 0, 0), 16'h00FF));
    vecs.push_back(v(1, 32'h44, 0, 0, 3, 0, w4(32'h11, 32'h22, 32'h33, 0), 16'h0FFF));
    vecs.push_back(v(0, 32'h0,  0, 0, 4, 1, w4(32'h11, 32'h22, 32'h33, 32'h44), 16'hFFFF));
    // partial flush of three lanes
    vecs.push_back(v(1, 32'hA, 0, 0, 0, 0, '0, 16'h0000));
    vecs.push_back(v(1, 32'hB, 0, 0, 1, 0, w4(32'hA, 0, 0, 0), 16'h000F));
    vecs.push_back(v(1, 32'hC, 0, 0, 2, 0, w4(32'hA, 32'hB, 0, 0), 16'h00FF));
    vecs.push_back(v(0, 32'h0, 1, 0, 3, 0, w4(32'hA, 32'hB, 32'hC, 0), 16'h0FFF));
    vecs.push_back(v(0, 32'h0, 0, 0, 3, 1, w4(32'hA, 32'hB, 32'hC, 0), 16'h0FFF));
    // flush on an empty word is ignored
    vecs.push_back(v(0, 32'h0, 1, 0, 0, 0, '0, 16'h0000));
    vecs.push_back(v(0, 32'h0, 0, 0, 0, 0, '0, 16'h0000));
    // flush together with the 4th push yields a full word
    vecs.push_back(v(1, 32'h1, 0, 0, 0, 0, '0, 16'h0000));
    vecs.push_back(v(1, 32'h2, 0, 0, 1, 0, w4(1, 0, 0, 0), 16'h000F));
    vecs.push_back(v(1, 32'h3, 0, 0, 2, 0, w4(1, 2, 0, 0), 16'h00FF));
    vecs.push_back(v(1, 32'h4, 1, 0, 3, 0, w4(1, 2, 3, 0), 16'h0FFF));
    vecs.push_back(v(0, 32'h0, 0, 0, 4, 1, w4(1, 2, 3, 4), 16'hFFFF));
    // flush with a same-cycle push on a partial word includes that push
    vecs.push_back(v(1, 32'h5, 0, 0, 0, 0, '0, 16'h0000));
    vecs.push_back(v(1, 32'h6, 1, 0, 1, 0, w4(5, 0, 0, 0), 16'h000F));
    vecs.push_back(v(0, 32'h0, 0, 0, 2, 1, w4(5, 6, 0, 0), 16'h00FF));
    // clear after 2 beats, with a discarded push in the clear cycle
    vecs.push_back(v(1, 32'h7,  0, 0, 0, 0, '0, 16'h0000));
    vecs.push_back(v(1, 32'h8,  0, 0, 1, 0, w4(7, 0, 0, 0), 16'h000F));
    vecs.push_back(v(1, 32'h99, 0, 1, 2, 0, w4(7, 8, 0, 0), 16'h00FF));
    // continuous streaming 1..8: count 1,2,3,4,1,2,3,4
    vecs.push_back(v(1, 32'h1, 0, 0, 0, 0, '0, 16'h0000));
    vecs.push_back(v(1, 32'h2, 0, 0, 1, 0, w4(1, 0, 0, 0), 16'h000F));
    vecs.push_back(v(1, 32'h3, 0, 0, 2, 0, w4(1, 2, 0, 0), 16'h00FF));
    vecs.push_back(v(1, 32'h4, 0, 0, 3, 0, w4(1, 2, 3, 0), 16'h0FFF));
    vecs.push_back(v(1, 32'h5, 0, 0, 4, 1, w4(1, 2, 3, 4), 16'hFFFF));
    vecs.push_back(v(1, 32'h6, 0, 0, 1, 0, w4(5, 0, 0, 0), 16'h000F));
    vecs.push_back(v(1, 32'h7, 0, 0, 2, 0, w4(5, 6, 0, 0), 16'h00FF));
    vecs.push_back(v(1, 32'h8, 0, 0, 3, 0, w4(5, 6, 7, 0), 16'h0FFF));
    vecs.push_back(v(0, 32'h0, 0, 0, 4, 1, w4(5, 6, 7, 8), 16'hFFFF));
    vecs.push_back(v(0, 32'h0, 0, 0, 0, 0, '0, 16'h0000));
    // partial byte strobe captured per lane
    t = v(1, 32'hAB, 0, 0, 0, 0, '0, 16'h0000);
    t.ps = 4'h3;
    vecs.push_back(t);
    vecs.push_back(v(0, 32'h0, 1, 0, 1, 0, w4(32'hAB, 0, 0, 0), 16'h0003));
    vecs.push_back(v(0, 32'h0, 0, 0, 1, 1, w4(32'hAB, 0, 0, 0), 16'h0003));
    vecs.push_back(v(0, 32'h0, 0, 0, 0, 0, '0, 16'h0000));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].pv, vecs[i].pd, vecs[i].ps, vecs[i].fl, vecs[i].cl, 1'b1);
      #1;
      chk($sformatf("vec%0d_count", i), 128'(count_o), 128'(vecs[i].ecnt));
      chk($sformatf("vec%0d_valid", i), 128'(pop_if.valid), 128'(vecs[i].ev));
      chk($sformatf("vec%0d_data", i), pop_if.data, vecs[i].ed);
      chk($sformatf("vec%0d_strb", i), 128'(pop_if.strb), 128'(vecs[i].es));
      chk($sformatf("vec%0d_pready", i), 128'(push_if.ready), 128'd1);
    end

    // backpressure: stall 5 cycles with a beat waiting
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      drive(1'b1, 32'(i), 4'hF, 1'b0, 1'b0, 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1'b1, 32'h5, 4'hF, 1'b0, 1'b0, 1'b0);
      #1;
      chk("bp_pready", 128'(push_if.ready), 128'd0);
      chk("bp_valid", 128'(pop_if.valid), 128'd1);
      chk("bp_data", pop_if.data, w4(1, 2, 3, 4));
    end
    @(negedge clk);
    pop_if.ready = 1'b1;
    #1 chk("bp_release_pready", 128'(push_if.ready), 128'd1);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("bp_after_count", 128'(count_o), 128'd1);
    chk("bp_after_valid", 128'(pop_if.valid), 128'd0);
    chk("bp_after_data", pop_if.data, w4(5, 0, 0, 0));
    chk("bp_after_strb", 128'(pop_if.strb), 128'h000F);
    @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    #1 chk("clr_count", 128'(count_o), 128'd0);

    // reset mid-fill
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'b1, 32'hDEAD0000 + 32'(i), 4'hF, 1'b0, 1'b0, 1'b1);
    end
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    rst_ni = 1'b0;
    #1 chk_reset_vals("rst_fill");
    @(negedge clk);
    rst_ni = 1'b1;
    run_basic("post_rst_fill");

    // reset while FULL and stalled
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 32'hBEEF0000 + 32'(i), 4'hF, 1'b0, 1'b0, 1'b1);
    end
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #1 chk("full_before_rst", 128'(pop_if.valid), 128'd1);
    @(negedge clk);
    rst_ni = 1'b0;
    #1 chk_reset_vals("rst_full");
    @(negedge clk);
    rst_ni = 1'b1;
    run_basic("post_rst_full");

    // randomized soak: 10% stalls on both sides, packed-in-order reference
    pv = 1'b0; pdat = '0; pstr = '0; hs_prev = 1'b0;
    sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < 256 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (hs_prev) pv = 1'b0;
      if (!pv && sent < 1024 && ($urandom % 10) != 0) begin
        pv   = 1'b1;
        pdat = $urandom;
        pstr = 4'($urandom);
      end
      drive(pv, pdat, pstr, 1'b0, 1'b0, ($urandom % 10) != 0);
      #1;
      push_hs = pv & push_if.ready;
      pop_hs  = pop_if.valid & pop_if.ready;
      if (pop_hs) begin
        if (exp_d.size() == 0) begin
          chk("soak_unexpected_beat", 128'(pop_if.valid), 128'd0);
        end else begin
          chk($sformatf("soak%0d_data", rcvd), pop_if.data, exp_d.pop_front());
          chk($sformatf("soak%0d_strb", rcvd), 128'(pop_if.strb), 128'(exp_s.pop_front()));
        end
        rcvd++;
      end
      if (push_hs) begin
        pend_d.push_back(pdat);
        pend_s.push_back(pstr);
        sent++;
        if (pend_d.size() == R) begin
          wd = '0;
          ws = '0;
          for (int k = 0; k < R; k++) begin
            wd[k*DW +: DW] = pend_d[k];
            ws[k*4 +: 4]   = pend_s[k];
          end
          pend_d.delete();
          pend_s.delete();
          exp_d.push_back(wd);
          exp_s.push_back(ws);
        end
      end
      hs_prev = push_hs;
    end
    chk("soak_beats_received", 128'(rcvd), 128'd256);
    chk("soak_beats_sent", 128'(sent), 128'd1024);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
